// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue sequencer: ALU control codes,
// ARM condition codes, sequencer states and NZCV bit positions.
package alu_pkg;

  // ALU control encodings (same values as the ALU's own header)
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  // ARM condition codes; NV (1111) is treated as always
  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_e;

  // Sequencer states: one ALU pass per LO/HI/FIX cycle
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LO   = 3'd1,
    ST_HI   = 3'd2,
    ST_FIX  = 3'd3,
    ST_RESP = 3'd4
  } state_e;

  // Bit positions inside a {N,Z,C,V} flag vector
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_cond_check.sv
// Combinational ARM condition-code evaluator against an NZCV vector.
module alu_cond_check
  import alu_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] nzcv_i,
  output logic       pass_o
);

  logic n, z, c, v;

  // Full ARM condition table; NV falls into the always-pass default
  always_comb begin
    n      = nzcv_i[FLAG_N];
    z      = nzcv_i[FLAG_Z];
    c      = nzcv_i[FLAG_C];
    v      = nzcv_i[FLAG_V];
    pass_o = 1'b1;
    case (cond_e'(cond_i))
      COND_EQ: pass_o = z;
      COND_NE: pass_o = ~z;
      COND_CS: pass_o = c;
      COND_CC: pass_o = ~c;
      COND_MI: pass_o = n;
      COND_PL: pass_o = ~n;
      COND_VS: pass_o = v;
      COND_VC: pass_o = ~v;
      COND_HI: pass_o = c & ~z;
      COND_LS: pass_o = ~c | z;
      COND_GE: pass_o = (n == v);
      COND_LT: pass_o = (n != v);
      COND_GT: pass_o = ~z & (n == v);
      COND_LE: pass_o = z | (n != v);
      default: pass_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_cond_sequencer.sv
// Issue-side controller for a combinational 32-bit ALU: conditional
// execution against NZCV, multi-pass 64-bit ops, and flag update.
module alu_cond_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [1:0]         req_op,
  input  logic               req_wide,
  input  logic [3:0]         req_cond,
  input  logic               req_setflags,
  input  logic [2*WIDTH-1:0] req_a,
  input  logic [2*WIDTH-1:0] req_b,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic [1:0]         alu_control,
  input  logic [WIDTH-1:0]   alu_result,
  input  logic [3:0]         alu_flags,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [2*WIDTH-1:0] rsp_result,
  output logic               rsp_executed,
  output logic [3:0]         nzcv
);

  state_e             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic               wide_q, wide_d;
  logic               setflags_q, setflags_d;
  logic [WIDTH-1:0]   a_hi_q, a_hi_d;
  logic [WIDTH-1:0]   b_hi_q, b_hi_d;
  logic [WIDTH-1:0]   res_lo_q, res_lo_d;
  logic               c0_q, c0_d;
  logic               c_hi_q, c_hi_d;
  logic [WIDTH-1:0]   alu_a_q, alu_a_d;
  logic [WIDTH-1:0]   alu_b_q, alu_b_d;
  logic [1:0]         alu_ctrl_q, alu_ctrl_d;
  logic [2*WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic               rsp_exec_q, rsp_exec_d;
  logic [3:0]         nzcv_q, nzcv_d;

  logic               cond_pass;
  logic               need_fix;
  logic               hi_carry;
  logic               b_eff_msb;
  logic [3:0]         wide_flags;
  logic [3:0]         narrow_flags;

  alu_cond_check u_cond (
    .cond_i (req_cond),
    .nzcv_i (nzcv_q),
    .pass_o (cond_pass)
  );

  assign req_ready    = (state_q == ST_IDLE);
  assign rsp_valid    = (state_q == ST_RESP);
  assign rsp_result   = rsp_result_q;
  assign rsp_executed = rsp_exec_q;
  assign nzcv         = nzcv_q;
  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign alu_control  = alu_ctrl_q;

  // Flag formation for the final pass: narrow from the ALU, wide assembled
  // from the saved low half, the high-pass carry and the current result.
  always_comb begin
    need_fix  = ((op_q == ALU_ADD) & c0_q) | ((op_q == ALU_SUB) & ~c0_q);
    // A SUB computes a + ~b + 1, so overflow uses the inverted b sign
    b_eff_msb = (op_q == ALU_SUB) ? ~b_hi_q[WIDTH-1] : b_hi_q[WIDTH-1];
    if (state_q == ST_FIX) begin
      hi_carry = (op_q == ALU_ADD) ? (c_hi_q | alu_flags[FLAG_C])
                                   : (c_hi_q & alu_flags[FLAG_C]);
    end else begin
      hi_carry = alu_flags[FLAG_C];
    end

    wide_flags         = nzcv_q;
    wide_flags[FLAG_N] = alu_result[WIDTH-1];
    wide_flags[FLAG_Z] = (res_lo_q == '0) && (alu_result == '0);
    if (!op_q[1]) begin
      wide_flags[FLAG_C] = hi_carry;
      wide_flags[FLAG_V] = (a_hi_q[WIDTH-1] == b_eff_msb) &
                           (alu_result[WIDTH-1] != a_hi_q[WIDTH-1]);
    end

    if (!op_q[1]) begin
      narrow_flags = alu_flags;
    end else begin
      narrow_flags         = nzcv_q;
      narrow_flags[FLAG_N] = alu_result[WIDTH-1];
      narrow_flags[FLAG_Z] = (alu_result == '0);
    end
  end

  // Next-state and datapath-register logic for the pass sequencer
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    wide_d       = wide_q;
    setflags_d   = setflags_q;
    a_hi_d       = a_hi_q;
    b_hi_d       = b_hi_q;
    res_lo_d     = res_lo_q;
    c0_d         = c0_q;
    c_hi_d       = c_hi_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_ctrl_d   = alu_ctrl_q;
    rsp_result_d = rsp_result_q;
    rsp_exec_d   = rsp_exec_q;
    nzcv_d       = nzcv_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          op_d       = req_op;
          wide_d     = req_wide;
          setflags_d = req_setflags;
          a_hi_d     = req_a[2*WIDTH-1:WIDTH];
          b_hi_d     = req_b[2*WIDTH-1:WIDTH];
          if (cond_pass) begin
            alu_a_d    = req_a[WIDTH-1:0];
            alu_b_d    = req_b[WIDTH-1:0];
            alu_ctrl_d = req_op;
            state_d    = ST_LO;
          end else begin
            rsp_result_d = '0;
            rsp_exec_d   = 1'b0;
            state_d      = ST_RESP;
          end
        end
      end

      ST_LO: begin
        res_lo_d = alu_result;
        c0_d     = alu_flags[FLAG_C];
        if (wide_q) begin
          alu_a_d = a_hi_q;
          alu_b_d = b_hi_q;
          state_d = ST_HI;
        end else begin
          rsp_result_d = {{WIDTH{1'b0}}, alu_result};
          rsp_exec_d   = 1'b1;
          if (setflags_q) nzcv_d = narrow_flags;
          state_d = ST_RESP;
        end
      end

      ST_HI: begin
        c_hi_d = alu_flags[FLAG_C];
        if (need_fix) begin
          // Propagate the low-half carry/borrow into the high word
          alu_a_d = alu_result;
          alu_b_d = WIDTH'(1);
          state_d = ST_FIX;
        end else begin
          rsp_result_d = {alu_result, res_lo_q};
          rsp_exec_d   = 1'b1;
          if (setflags_q) nzcv_d = wide_flags;
          state_d = ST_RESP;
        end
      end

      ST_FIX: begin
        rsp_result_d = {alu_result, res_lo_q};
        rsp_exec_d   = 1'b1;
        if (setflags_q) nzcv_d = wide_flags;
        state_d = ST_RESP;
      end

      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset drops any in-flight op
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      op_q         <= ALU_ADD;
      wide_q       <= 1'b0;
      setflags_q   <= 1'b0;
      a_hi_q       <= '0;
      b_hi_q       <= '0;
      res_lo_q     <= '0;
      c0_q         <= 1'b0;
      c_hi_q       <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_ctrl_q   <= ALU_ADD;
      rsp_result_q <= '0;
      rsp_exec_q   <= 1'b0;
      nzcv_q       <= 4'b0000;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      wide_q       <= wide_d;
      setflags_q   <= setflags_d;
      a_hi_q       <= a_hi_d;
      b_hi_q       <= b_hi_d;
      res_lo_q     <= res_lo_d;
      c0_q         <= c0_d;
      c_hi_q       <= c_hi_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_ctrl_q   <= alu_ctrl_d;
      rsp_result_q <= rsp_result_d;
      rsp_exec_q   <= rsp_exec_d;
      nzcv_q       <= nzcv_d;
    end
  end

endmodule
